// File: rtl/dn_pkg.sv
// Shared types and limits for the download stream transmitter.
package dn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WRITE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    localparam int GAP_MAX = 15;
    localparam int GAP_W   = 4;

    // Out-of-range GAP values saturate so the gap counter width always suffices.
    function automatic logic [GAP_W-1:0] gap_clamp(input int g);
        logic [GAP_W-1:0] r;
        if (g > GAP_MAX) begin
            r = GAP_W'(GAP_MAX);
        end else if (g < 0) begin
            r = {GAP_W{1'b0}};
        end else begin
            r = GAP_W'(g);
        end
        return r;
    endfunction

endpackage

// File: rtl/dn_stream_tx.sv
// Streams source bytes into a download port as spaced write strobes, with
// one FSM plus byte-count and gap counters.
module dn_stream_tx
    import dn_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int GAP    = 3
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [7:0]        dn_data,
    output logic              dn_wr,
    output logic              dn_active,
    output logic              done,
    output logic              aborted
);

    localparam logic [GAP_W-1:0] GAP_CYC  = gap_clamp(GAP);
    localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
    localparam logic [GAP_W-1:0] GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]  CNT_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]  CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              wr_q, wr_d;
    logic              active_q, active_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    // Next-state, counter and output-register decode.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        len_d     = len_q;
        gap_d     = gap_q;
        addr_d    = addr_q;
        data_d    = data_q;
        aborted_d = 1'b0;

        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (length == CNT_ZERO) begin
                            state_d = ST_FINISH;
                        end else begin
                            len_d   = length;
                            count_d = CNT_ZERO;
                            state_d = ST_FETCH;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (s_valid) begin
                        data_d  = s_data;
                        addr_d  = count_q[ADDR_W-1:0];
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_WRITE: begin
                    // count never exceeds len_q, so the extra top bit absorbs 2^ADDR_W.
                    count_d = count_q + CNT_ONE;
                    if (GAP_CYC != GAP_ZERO) begin
                        gap_d   = GAP_CYC - GAP_ONE;
                        state_d = ST_GAP;
                    end else if (count_d == len_q) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_GAP: begin
                    if (gap_q != GAP_ZERO) begin
                        gap_d = gap_q - GAP_ONE;
                    end else if (count_q == len_q) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_FINISH: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        wr_d     = (state_d == ST_WRITE);
        active_d = (state_d == ST_FETCH) || (state_d == ST_WRITE) || (state_d == ST_GAP);
        done_d   = (state_d == ST_FINISH);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            count_q   <= CNT_ZERO;
            len_q     <= CNT_ZERO;
            gap_q     <= GAP_ZERO;
            addr_q    <= {ADDR_W{1'b0}};
            data_q    <= 8'h00;
            wr_q      <= 1'b0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            active_q  <= active_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign s_ready   = (state_q == ST_FETCH);
    assign dn_addr   = addr_q;
    assign dn_data   = data_q;
    assign dn_wr     = wr_q;
    assign dn_active = active_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule
